// File: rtl/jt900h_pkg.sv
// Shared constants for the jt900h memory wait-state bridge.
package jt900h_pkg;

  // Default CPU byte-address width.
  localparam int AW_DEF = 24;

  // Bridge FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/jt900h_memwait_if.sv
// CPU-side and memory-side bus bundle for jt900h_memwait.
//
// Memory handshake: mem_req is a level. While it is high, mem_we, mem_addr,
// mem_wdata and mem_wmask stay stable. The memory answers with mem_ok for one
// or more cycles; the first cycle with mem_req=1 and mem_ok=1 completes the
// transfer, and mem_rdata is sampled on that cycle for reads. A new request
// only rises after mem_ok has been seen low again.
interface jt900h_memwait_if
  import jt900h_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          cen;
  logic          cpu_cen;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    cpu_we;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_wmask;
  logic          mem_ok;
  logic [15:0]   mem_rdata;

  // Bridge side.
  modport master (
    input  cen, cpu_addr, cpu_we, cpu_wdata, mem_ok, mem_rdata,
    output cpu_cen, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  // CPU plus memory side.
  modport slave (
    output cen, cpu_addr, cpu_we, cpu_wdata, mem_ok, mem_rdata,
    input  cpu_cen, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/jt900h_memwait_line.sv
// One-entry read line: valid/tag/data, hit compare and lane-masked
// write-through update.
module jt900h_memwait_line
  import jt900h_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-2:0] cmp_addr,   // word address the CPU is presenting
  input  logic [AW-2:0] acc_addr,   // word address of the completing access
  input  logic          ld,         // read ack: refill the line
  input  logic [15:0]   ld_data,
  input  logic          wr,         // write ack: patch lanes on a tag match
  input  logic [15:0]   wr_data,
  input  logic [1:0]    wr_mask,
  output logic          hit,
  output logic          valid,
  output logic [15:0]   data
);

  logic          valid_q, valid_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [15:0]   data_q, data_d;

  // Next line contents from a read refill or a write-through patch.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (ld) begin
      valid_d = 1'b1;
      tag_d   = acc_addr;
      data_d  = ld_data;
    end else if (wr && valid_q && (tag_q == acc_addr)) begin
      if (wr_mask[1]) data_d[15:8] = wr_data[15:8];
      if (wr_mask[0]) data_d[7:0]  = wr_data[7:0];
    end
  end

  // Line registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit   = valid_q & (tag_q == cmp_addr);
  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/jt900h_memwait.sv
// Wait-state bridge between the jt900h RAM port and a req/ok memory.
// The CPU is frozen through cpu_cen until each access completes.
module jt900h_memwait
  import jt900h_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  jt900h_memwait_if.master      bus,
  output logic [1:0]            dbg_state,
  output logic                  dbg_valid
);

  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-2:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_wmask_q, mem_wmask_d;
  logic          wr_done_q, wr_done_d;

  logic          hit, line_valid, line_ld, line_wr;
  logic [15:0]   line_data;
  logic          wr_pend, rd_miss, stall, cpu_cen;
  logic          unused_addr0;

  // Byte address bit 0 has no meaning on a 16-bit word port.
  assign unused_addr0 = bus.cpu_addr[0];

  jt900h_memwait_line #(.AW(AW)) u_line (
    .clk      (clk),
    .rst      (rst),
    .cmp_addr (bus.cpu_addr[AW-1:1]),
    .acc_addr (mem_addr_q),
    .ld       (line_ld),
    .ld_data  (bus.mem_rdata),
    .wr       (line_wr),
    .wr_data  (mem_wdata_q),
    .wr_mask  (mem_wmask_q),
    .hit      (hit),
    .valid    (line_valid),
    .data     (line_data)
  );

  // A write stays pending until acked; wr_done keeps the same CPU write
  // from being issued twice while the CPU is still frozen on it.
  assign wr_pend = (bus.cpu_we != 2'b00) & ~wr_done_q;
  assign rd_miss = (bus.cpu_we == 2'b00) & ~hit;
  assign stall   = (state_q != ST_IDLE) | wr_pend | rd_miss;
  assign cpu_cen = bus.cen & ~stall & ~rst;

  // FSM next state, request launch and line update strobes.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    wr_done_d   = wr_done_q;
    line_ld     = 1'b0;
    line_wr     = 1'b0;
    if (cpu_cen) wr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_pend) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.cpu_addr[AW-1:1];
          mem_wdata_d = bus.cpu_wdata;
          mem_wmask_d = bus.cpu_we;
        end else if (rd_miss) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.cpu_addr[AW-1:1];
          mem_wmask_d = 2'b11;
        end
      end
      ST_REQ: begin
        if (bus.mem_ok) begin
          state_d   = ST_HOLD;
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            line_wr   = 1'b1;
            wr_done_d = 1'b1;
          end else begin
            line_ld   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Wait out a long ack so the next request cannot merge with it.
        if (!bus.mem_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and memory-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign bus.cpu_cen   = cpu_cen;
  assign bus.cpu_rdata = line_data;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign dbg_state     = state_q;
  assign dbg_valid     = line_valid;

endmodule

// File: doc/jt900h_memwait.md
# jt900h_memwait

Memory wait-state bridge placed directly downstream of the jt900h CPU's RAM port. It turns the CPU's zero-wait 16-bit interface into a req/ok handshake toward external memory (SDRAM/BRAM arbiter), and freezes the CPU by gating its clock enable until each access completes. A one-entry read line, with write-through lane update, lets repeated fetches of the same word run with no wait states.

## Interface
Parameters
- AW, 24: CPU byte-address width; memory word address is AW-1 bits.

Ports
- clk  in  1  system clock. Memory side runs on every clk edge.
- rst  in  1  asynchronous, active-high reset.
- cen  in  1  master clock enable for the CPU domain.
- cpu_cen  out  1  gated enable to the CPU: cen & ~stall; forced 0 while rst is high.
- cpu_addr  in  AW  CPU byte address (ram_addr); bit 0 ignored.
- cpu_we  in  2  CPU byte-lane write strobes (ram_we); [1]=high byte.
- cpu_wdata  in  16  CPU write data (ram_din).
- cpu_rdata  out  16  read data to the CPU (ram_dout), from the line register; reset 0.
- mem_req  out  1  request level; reset 0.
- mem_we  out  1  1 = write transaction; reset 0.
- mem_addr  out  AW-1  word address; reset 0.
- mem_wdata  out  16  write data; reset 0.
- mem_wmask  out  2  active-high lane mask; reset 0.
- mem_ok  in  1  acknowledge, one or more cycles.
- mem_rdata  in  16  read data, valid when mem_ok=1 on a read.

## Operation
- Line state: valid (reset 0), tag[AW-2:0] (reset 0), data[15:0] (reset 0). cpu_rdata = data.
- hit = valid & (tag == cpu_addr[AW-1:1]).
- wr_pend = (cpu_we != 0) & ~wr_done. wr_done resets to 0, sets on write ack, and clears on any cycle with cpu_cen=1.
- stall = (state != IDLE) | wr_pend | (cpu_we == 0 & ~hit). This term is combinational from cpu_addr/cpu_we, so the CPU never samples stale data.
- FSM states:
  - IDLE -> REQ on a write (wr_pend): mem_we=1, mem_wmask=cpu_we, wdata/addr latched.
  - IDLE -> REQ on a read miss: mem_we=0, mask=2'b11. A write has priority over a read miss in the same cycle.
  - REQ: hold all mem_* outputs stable, mem_req=1. When mem_ok=1: drop mem_req and go to HOLD.
    - On a read: data<=mem_rdata, tag<=addr, valid<=1.
    - On a write: wr_done<=1; if the write address equals tag and valid=1, update the masked lanes of data from wdata.
  - HOLD -> IDLE once mem_ok=0. HOLD can be left in the same cycle it is entered if mem_ok is already low. mem_ok is ignored outside REQ.
- The FSM advances on every clk regardless of cen. cen only affects cpu_cen.
- Reset mid-transaction: mem_req drops asynchronously, valid=0, FSM goes to IDLE. Memory must tolerate an abandoned request.

## Timing
- Read miss first visible in cycle 0 -> mem_req=1 from cycle 1.
- If mem_ok=1 in cycle k (k>=1), mem_req=0 and cpu_rdata is valid from cycle k+1.
- cpu_cen may pulse in cycle k+2 at the earliest (HOLD->IDLE with mem_ok low in k+1), or later depending on cen.
- Read hit: zero added latency; cpu_cen=cen in the same cycle.
- Write: same handshake timing as a read. Exactly one memory write is issued per CPU-enabled cycle that has cpu_we!=0.
- Back-to-back: a new mem_req never rises while mem_ok is still high from the previous ack.

## Structure
- jt900h_pkg holds the shared AW default and the FSM state constants (IDLE=0, REQ=1, HOLD=2, 2-bit encoding).
- One sub-module is natural: jt900h_memwait_line, holding the valid/tag/data registers, the hit compare and the lane-masked update. The top level keeps the FSM, wr_done and the output muxing.

## Test plan
- Read miss: addr 0x000100, mem_ok 3 cycles after req with rdata 0xBEEF -> mem_addr 0x000080, cpu_cen 0 throughout, cpu_rdata=0xBEEF, then a single cpu_cen pulse.
- Read hit: repeat addr 0x000101 -> no mem_req; cpu_cen follows cen; cpu_rdata still 0xBEEF.
- Byte write hit: cpu_we=2'b01, wdata 0x1234 at 0x000100 -> mem_wmask=01, one mem_req; afterwards cpu_rdata=0xBE34, valid still 1.
- Write/read priority: write to 0x000200 while line tag is 0x000100 -> one write request, line unchanged. The following read of 0x000200 misses and issues a read.
- mem_ok held high for 4 cycles after ack -> FSM remains in HOLD, no new mem_req until mem_ok falls.
- Reset mid-REQ -> mem_req=0 immediately, cpu_cen=0 during reset, cpu_rdata=0, valid=0. The next read of the old address misses.
